// File: rtl/conv_delay_line.sv
// Multi-lane, runtime-length delay line with valid/ready flow control and full tap visibility.
// Latency: sample k leaves on out_data after push k+len_q; one register stage from sr to out_data.
// Backpressure: out_valid && !out_ready drops in_ready and freezes every stage; flush also drops in_ready.
module conv_delay_line #(
   parameter int WIDTH     = 18,
   parameter int MAX_DEPTH = 16,
   parameter int CHANNELS  = 1,
   localparam int LEN_W    = $clog2(MAX_DEPTH + 1)
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                flush,
   input  logic [LEN_W-1:0]                    cfg_len,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [WIDTH*CHANNELS-1:0]           in_data,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [WIDTH*CHANNELS-1:0]           out_data,
   output logic [WIDTH*MAX_DEPTH*CHANNELS-1:0] taps,
   output logic [LEN_W-1:0]                    fill_count,
   output logic                                primed
);

   localparam int IDX_W = $clog2(MAX_DEPTH);

   logic [WIDTH-1:0] sr [CHANNELS][MAX_DEPTH];
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] len_clamped;
   logic [IDX_W-1:0] sel;
   logic             push;

   always_comb begin
      len_clamped = cfg_len;
      if (cfg_len == '0)
         len_clamped = LEN_W'(1);
      else if (cfg_len > LEN_W'(MAX_DEPTH))
         len_clamped = LEN_W'(MAX_DEPTH);
   end

   assign in_ready = !flush && (!out_valid || out_ready);
   assign push     = in_valid && in_ready;
   assign primed   = (fill_count == len_q);
   // len_q is always in 1..MAX_DEPTH, so len_q-1 fits the stage index
   assign sel      = IDX_W'(len_q - LEN_W'(1));

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         len_q      <= len_clamped;
         fill_count <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         for (int c = 0; c < CHANNELS; c++)
            for (int i = 0; i < MAX_DEPTH; i++)
               sr[c][i] <= '0;
      end else if (push) begin
         for (int c = 0; c < CHANNELS; c++) begin
            out_data[c*WIDTH +: WIDTH] <= sr[c][sel];
            sr[c][0] <= in_data[c*WIDTH +: WIDTH];
            for (int i = 1; i < MAX_DEPTH; i++)
               sr[c][i] <= sr[c][i-1];
         end
         out_valid <= (fill_count == len_q);
         if (fill_count != len_q)
            fill_count <= fill_count + LEN_W'(1);
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
      for (genvar i = 0; i < MAX_DEPTH; i++) begin : g_stage
         assign taps[(c*MAX_DEPTH + i)*WIDTH +: WIDTH] = sr[c][i];
      end
   end

   a_fill_bound : assert property (@(posedge clk) disable iff (rst) fill_count <= len_q);
   a_hold_stall : assert property (@(posedge clk) disable iff (rst)
      (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data)));

endmodule

// File: tb/tb_conv_delay_line.sv
// Randomized scoreboard bench for conv_delay_line (3 lanes, 16 stages).
// The model keeps every accepted sample since the last clear and predicts outputs by index arithmetic.
module tb_conv_delay_line;

   localparam int W = 18;
   localparam int D = 16;
   localparam int C = 3;
   localparam int LW = $clog2(D + 1);
   typedef logic [W*C-1:0] vec_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             flush = 1'b0;
   logic [LW-1:0]    cfg_len = LW'(5);
   logic             in_valid = 1'b0;
   logic             in_ready;
   vec_t             in_data = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   vec_t             out_data;
   logic [W*D*C-1:0] taps;
   logic [LW-1:0]    fill_count;
   logic             primed;

   conv_delay_line #(.WIDTH(W), .MAX_DEPTH(D), .CHANNELS(C)) dut (
      .clk(clk), .rst(rst), .flush(flush), .cfg_len(cfg_len),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .taps(taps), .fill_count(fill_count), .primed(primed)
   );

   always #5 clk = ~clk;

   int   total = 0;
   int   passed = 0;
   vec_t hist[$];
   vec_t exp_q[$];
   int   m_len = 1;

   function automatic int clampf(input int l);
      if (l == 0) return 1;
      if (l > D) return D;
      return l;
   endfunction

   function automatic vec_t mk(input int k);
      vec_t v;
      for (int c = 0; c < C; c++) v[c*W +: W] = W'(c*100 + k);
      return v;
   endfunction

   task automatic chk(input string name, input longint act, input longint req);
      total++;
      if (act == req) passed++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
   endtask

   // Reference model: checks state-like outputs, then records the push that the next edge performs
   always @(negedge clk) begin
      int   n;
      bit   rdy;
      int   bad_i;
      int   bad_c;
      vec_t e;
      if (rst) begin
         hist.delete();
         exp_q.delete();
         m_len = clampf(int'(cfg_len));
      end else if (flush) begin
         chk("in_ready_flush", in_ready, 0);
         hist.delete();
         exp_q.delete();
         m_len = clampf(int'(cfg_len));
      end else begin
         n   = hist.size();
         rdy = (exp_q.size() == 0) || out_ready;
         chk("in_ready", in_ready, rdy);
         chk("fill_count", fill_count, (n < m_len) ? n : m_len);
         chk("primed", primed, n >= m_len);
         bad_i = -1;
         bad_c = 0;
         for (int i = 0; i < D; i++) begin
            e = (n - 1 - i >= 0) ? hist[n-1-i] : '0;
            for (int c = 0; c < C; c++)
               if (bad_i < 0 && taps[(c*D+i)*W +: W] != e[c*W +: W]) begin
                  bad_i = i;
                  bad_c = c;
               end
         end
         total++;
         if (bad_i < 0) passed++;
         else begin
            e = (n - 1 - bad_i >= 0) ? hist[n-1-bad_i] : '0;
            $display("FAIL taps lane %0d stage %0d: got %0h expected %0h at %0t", bad_c, bad_i,
                     taps[(bad_c*D+bad_i)*W +: W], e[bad_c*W +: W], $time);
         end
         if (in_valid && rdy) begin
            if (n >= m_len) exp_q.push_back(hist[n-m_len]);
            hist.push_back(in_data);
         end
      end
   end

   // Monitor: pops one expectation per accepted output
   always @(negedge clk) begin
      vec_t e;
      #2;
      if (!rst && !flush && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            $display("FAIL out_unexpected: got out_valid=1 data %0h expected no output at %0t",
                     out_data, $time);
         end else begin
            e = exp_q.pop_front();
            for (int c = 0; c < C; c++)
               chk($sformatf("out_data_lane%0d", c), out_data[c*W +: W], e[c*W +: W]);
         end
      end
   end

   task automatic drive(input bit v, input vec_t d, input bit r, input bit f, input int cl);
      @(posedge clk);
      #1;
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      flush     = f;
      cfg_len   = LW'(cl);
   endtask

   task automatic do_reset(input int cl);
      @(posedge clk);
      #1;
      rst      = 1'b1;
      in_valid = 1'b0;
      flush    = 1'b0;
      cfg_len  = LW'(cl);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   function automatic vec_t rnd_vec();
      vec_t v;
      for (int c = 0; c < C; c++) v[c*W +: W] = W'($urandom);
      return v;
   endfunction

   initial begin
      // reset with len 5, then samples 1..6
      do_reset(5);
      for (int k = 1; k <= 6; k++) drive(1, mk(k), 1, 0, 5);
      drive(0, '0, 1, 0, 9);
      // delay order with len 3
      drive(0, '0, 1, 1, 3);
      for (int k = 1; k <= 6; k++) drive(1, mk(k), 1, 0, 7);
      drive(0, '0, 1, 0, 7);
      // backpressure with len 2
      drive(0, '0, 1, 1, 2);
      for (int k = 10; k <= 12; k++) drive(1, mk(k), 1, 0, 2);
      for (int s = 0; s < 3; s++) drive(1, mk(13), 0, 0, 2);
      for (int k = 13; k <= 20; k++) drive(1, mk(k), 1, 0, 2);
      drive(0, '0, 1, 0, 2);
      // flush arriving together with a valid sample
      drive(0, '0, 1, 1, 4);
      for (int k = 1; k <= 7; k++) drive(1, mk(k), 1, 0, 4);
      drive(1, mk(99), 1, 1, 2);
      for (int k = 50; k <= 55; k++) drive(1, mk(k), 1, 0, 4);
      // clamp low and high, cfg_len wiggling in between
      drive(0, '0, 1, 1, 0);
      for (int s = 0; s < 30; s++) drive($urandom_range(0, 3) != 0, rnd_vec(), $urandom_range(0, 3) != 0, 0, $urandom_range(0, 20));
      drive(0, '0, 1, 1, 20);
      for (int s = 0; s < 60; s++) drive($urandom_range(0, 4) != 0, rnd_vec(), $urandom_range(0, 3) != 0, 0, $urandom_range(0, 20));
      // random traffic, occasional flush and mid-stream reset
      for (int s = 0; s < 2000; s++) begin
         if ($urandom_range(0, 199) == 0) do_reset($urandom_range(0, 20));
         else drive($urandom_range(0, 9) < 8, rnd_vec(), $urandom_range(0, 9) < 7,
                    $urandom_range(0, 59) == 0, $urandom_range(0, 20));
      end
      // drain
      for (int s = 0; s < 4; s++) drive(0, '0, 1, 0, 1);
      @(negedge clk);
      #5;
      chk("drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
